// File: rtl/bip_i.sv
// rtl/bip_i.sv - BIP I accumulator processor with built-in program and UART result dump
// Runs the ROM program until HLT, then sends ACC and the instruction count as four 8N1 bytes.
module bip_i #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          PC_W         = 11,
    parameter int          DADDR_W      = 10,
    parameter logic [15:0] PROG [16]    = '{
        16'h1805, 16'h0800, 16'h2803, 16'h2000,
        16'h3801, 16'h0801, 16'h3000, 16'h1001,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    }
) (
    input  logic CLK,
    input  logic RESET,
    output logic TX
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        cyc_q, cyc_d;
    logic               halted_q, halted_d;
    logic [15:0]        ram_q [2**DADDR_W];

    logic [15:0]        instr;
    logic [4:0]         op;
    logic [10:0]        operand;
    logic [15:0]        imm;
    logic [DADDR_W-1:0] addr;
    logic [15:0]        rdata;
    logic               ram_we;

    // Only the first 16 ROM words are programmable; the rest decode as HLT.
    assign instr   = (pc_q[PC_W-1:4] == '0) ? PROG[pc_q[3:0]] : 16'h0000;
    assign op      = instr[15:11];
    assign operand = instr[10:0];
    assign imm     = {{5{operand[10]}}, operand};
    assign addr    = operand[DADDR_W-1:0];
    assign rdata   = ram_q[addr];

    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        cyc_d    = cyc_q;
        halted_d = halted_q;
        ram_we   = 1'b0;
        if (!halted_q) begin
            if (op == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
                if (cyc_q != 16'hFFFF) begin
                    cyc_d = cyc_q + 16'd1;
                end
                case (op)
                    OP_STO:  ram_we = 1'b1;
                    OP_LD:   acc_d  = rdata;
                    OP_LDI:  acc_d  = imm;
                    OP_ADD:  acc_d  = acc_q + rdata;
                    OP_ADDI: acc_d  = acc_q + imm;
                    OP_SUB:  acc_d  = acc_q - rdata;
                    OP_SUBI: acc_d  = acc_q - imm;
                    default: acc_d  = acc_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q     <= '0;
            acc_q    <= '0;
            cyc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            cyc_q    <= cyc_d;
            halted_q <= halted_d;
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[addr] <= acc_q;
        end
    end

    typedef enum logic [2:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP,
        U_DONE
    } ustate_t;

    ustate_t          ustate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [1:0]       byte_q;
    logic [7:0]       sh_q;
    logic             tx_q;
    logic [31:0]      tx_word;

    assign tx_word = {acc_q, cyc_q};

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [31:0] w);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ustate_q <= U_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (ustate_q)
                U_IDLE: begin
                    tx_q <= 1'b1;
                    if (halted_q) begin
                        ustate_q <= U_START;
                        cnt_q    <= '0;
                        byte_q   <= 2'd0;
                        sh_q     <= frame_byte(2'd0, tx_word);
                        tx_q     <= 1'b0;
                    end
                end
                U_START: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        ustate_q <= U_DATA;
                        tx_q     <= sh_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            ustate_q <= U_STOP;
                            tx_q     <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            sh_q  <= {1'b0, sh_q[7:1]};
                            tx_q  <= sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (byte_q == 2'd3) begin
                            ustate_q <= U_DONE;
                            tx_q     <= 1'b1;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            byte_q   <= byte_q + 1'b1;
                            sh_q     <= frame_byte(byte_q + 1'b1, tx_word);
                            ustate_q <= U_START;
                            tx_q     <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    ustate_q <= U_DONE;
                    tx_q     <= 1'b1;
                end
            endcase
        end
    end

    assign TX = tx_q;

endmodule

// File: tb/tb_bip_i.sv
// tb/tb_bip_i.sv - self-checking bench for bip_i: execution, halt state and UART frames
module tb_bip_i;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;

    localparam logic [15:0] PROG_B [16] = '{
        16'h1FFF, 16'h2801, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    logic CLK = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic tx_a, tx_b;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc_cnt = 0;
    logic [7:0]  sb_q [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    bip_i dut_a (.CLK(CLK), .RESET(rst_a), .TX(tx_a));
    bip_i #(.PROG(PROG_B)) dut_b (.CLK(CLK), .RESET(rst_b), .TX(tx_b));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out or no expected data", nm);
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic [15:0] get_state(input int sel);
        logic [15:0] v;
        case (sel)
            0:       v = 16'(dut_a.pc_q);
            1:       v = dut_a.acc_q;
            2:       v = dut_a.cyc_q;
            3:       v = 16'(dut_a.halted_q);
            4:       v = dut_a.ram_q[0];
            5:       v = dut_a.ram_q[1];
            6:       v = 16'(tx_a);
            7:       v = dut_b.acc_q;
            8:       v = dut_b.cyc_q;
            default: v = 16'(dut_b.pc_q);
        endcase
        return v;
    endfunction

    task automatic run_table(input chk_t t [$]);
        foreach (t[i]) check(t[i].name, 32'(get_state(t[i].sel)), 32'(t[i].exp));
    endtask

    task automatic push_frame(input logic [15:0] acc, input logic [15:0] cyc);
        sb_q.push_back(acc[15:8]);
        sb_q.push_back(acc[7:0]);
        sb_q.push_back(cyc[15:8]);
        sb_q.push_back(cyc[7:0]);
    endtask

    task automatic wait_start(input int w, input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (get_tx(w) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) expire(nm);
    endtask

    // Called at the negedge where the start bit was first seen.
    task automatic rx_body(input int w, input string nm);
        logic [7:0] b;
        logic       st, sp;
        repeat (8) @(negedge CLK);
        st = get_tx(w);
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge CLK);
            b[k] = get_tx(w);
        end
        repeat (16) @(negedge CLK);
        sp = get_tx(w);
        check({nm, "_framing"}, {30'd0, st, sp}, 32'd1);
        if (sb_q.size() == 0) expire({nm, "_scoreboard"});
        else check(nm, 32'(b), 32'(sb_q.pop_front()));
    endtask

    task automatic rx_frame(input int w, input string tag, output int unsigned first);
        int unsigned s [4];
        bit ok;
        first = 0;
        for (int i = 0; i < 4; i++) begin
            wait_start(w, $sformatf("%s_start%0d", tag, i), ok);
            if (!ok) return;
            s[i] = cyc_cnt;
            rx_body(w, $sformatf("%s_byte%0d", tag, i));
        end
        for (int i = 1; i < 4; i++) check($sformatf("%s_spacing%0d", tag, i), s[i] - s[i-1], 32'd160);
        first = s[0];
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_t        rst_tbl [$];
        chk_t        halt_tbl [$];
        chk_t        b_tbl [$];
        int unsigned rel, first;
        int          tx_low;
        bit          ok;
        logic        tx_before;

        rst_tbl = '{
            '{"rst_pc", 0, 16'h0000}, '{"rst_acc", 1, 16'h0000},
            '{"rst_cyc", 2, 16'h0000}, '{"rst_halted", 3, 16'h0000},
            '{"rst_tx", 6, 16'h0001}
        };
        halt_tbl = '{
            '{"halt_pc", 0, 16'h0008}, '{"halt_acc", 1, 16'h000C},
            '{"halt_cyc", 2, 16'h0008}, '{"halt_ram0", 4, 16'h0005},
            '{"halt_ram1", 5, 16'h000C}, '{"halt_flag", 3, 16'h0001}
        };
        b_tbl = '{
            '{"b_acc", 7, 16'h0000}, '{"b_cyc", 8, 16'h0002}, '{"b_pc", 9, 16'h0002}
        };

        #98;
        run_table(rst_tbl);

        @(negedge CLK);
        rst_a = 1'b0;
        rel = cyc_cnt;
        push_frame(16'h000C, 16'h0008);
        tx_low = 0;
        repeat (8) begin
            @(negedge CLK);
            if (!tx_a) tx_low++;
        end
        check("pc_before_halt", 32'(dut_a.pc_q), 32'd8);
        check("not_halted_at_8", 32'(dut_a.halted_q), 32'd0);
        @(negedge CLK);
        if (!tx_a) tx_low++;
        check("tx_high_during_exec", tx_low, 0);
        run_table(halt_tbl);

        rx_frame(0, "a", first);
        check("tx_start_latency", first - rel, 32'd10);

        tx_low = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (!tx_a) tx_low++;
        end
        check("no_retransmit", tx_low, 0);
        check("scoreboard_drained", sb_q.size(), 0);
        check("frozen_acc", 32'(dut_a.acc_q), 32'h000C);

        // Rerun, then reset in the middle of the second byte.
        @(negedge CLK);
        rst_a = 1'b1;
        repeat (3) @(negedge CLK);
        rst_a = 1'b0;
        push_frame(16'h000C, 16'h0008);
        wait_start(0, "mid_start0", ok);
        if (ok) rx_body(0, "mid_byte0");
        wait_start(0, "mid_start1", ok);
        tx_before = tx_a;
        #1;
        rst_a = 1'b1;
        #1;
        check("mid_tx_before_reset", 32'(tx_before), 32'd0);
        check("mid_tx_async_high", 32'(tx_a), 32'd1);
        check("mid_pc_reset", 32'(dut_a.pc_q), 32'd0);
        check("mid_acc_reset", 32'(dut_a.acc_q), 32'd0);
        sb_q.delete();
        repeat (5) @(negedge CLK);
        rst_a = 1'b0;
        push_frame(16'h000C, 16'h0008);
        rx_frame(0, "rerun", first);
        run_table(halt_tbl);

        @(negedge CLK);
        rst_b = 1'b0;
        push_frame(16'h0000, 16'h0002);
        rx_frame(1, "b", first);
        run_table(b_tbl);
        check("b_scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
